// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// D-stage hazard detection for the five-stage MIPS pipeline. It keeps its own
// copy of the writers in flight in E, M and W as {we, wa, tnew} and counts
// their tnew down each cycle. From these it drives the D-stage stall and the
// D-stage forward selects that the beq/jr comparators use.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   d_valid               D stage holds a real instruction
//   d_re1/d_ra1/d_tuse_rs rs read enable, address, cycles until it is consumed
//   d_re2/d_ra2/d_tuse_rt rt read enable, address, cycles until it is consumed
//   d_we/d_wa/d_tnew      GRF write enable, address, cycles after E until ready
//   flush                 kill the instruction entering E
//   stall                 freeze PC and F/D, put a bubble into E
//   fwd_rs_sel/fwd_rt_sel D-stage operand source: 0=GRF 1=E 2=M 3=W
//   e_tnew, m_tnew        current tnew of the E and M entries
//   stall_cnt, bubble_cnt only when HAZARD_STATS_EN is defined; they count
//                         stalled edges and edges that put a bubble into E
module hazard_scoreboard #(
    parameter int AW = 5,
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          d_valid,
    input  logic          d_re1,
    input  logic          d_re2,
    input  logic [AW-1:0] d_ra1,
    input  logic [AW-1:0] d_ra2,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic          d_we,
    input  logic [AW-1:0] d_wa,
    input  logic [TW-1:0] d_tnew,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_rs_sel,
    output logic [1:0]    fwd_rt_sel,
    output logic [TW-1:0] e_tnew,
    output logic [TW-1:0] m_tnew
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   bubble_cnt
`endif
);

    logic          e_we_q, e_we_d, m_we_q, m_we_d, w_we_q, w_we_d;
    logic [AW-1:0] e_wa_q, e_wa_d, m_wa_q, m_wa_d, w_wa_q, w_wa_d;
    logic [TW-1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;

    logic rs_e, rs_m, rs_w, rt_e, rt_m, rt_w;
    logic stall_rs, stall_rt, bubble;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - TW'(1);
    endfunction

    // The youngest match decides. If it is not ready yet the operand reads the
    // GRF path here, and the downstream forward muxes pick it up later.
    function automatic logic [1:0] pick_sel(input logic me, input logic mm,
                                            input logic mw,
                                            input logic [TW-1:0] te,
                                            input logic [TW-1:0] tm,
                                            input logic [TW-1:0] tw);
        if (me)      return (te == '0) ? 2'd1 : 2'd0;
        else if (mm) return (tm == '0) ? 2'd2 : 2'd0;
        else if (mw) return (tw == '0) ? 2'd3 : 2'd0;
        else         return 2'd0;
    endfunction

    always_comb begin
        // $0 is hardwired, so it never creates a hazard.
        rs_e = d_valid & d_re1 & (d_ra1 != '0) & e_we_q & (e_wa_q == d_ra1);
        rs_m = d_valid & d_re1 & (d_ra1 != '0) & m_we_q & (m_wa_q == d_ra1);
        rs_w = d_valid & d_re1 & (d_ra1 != '0) & w_we_q & (w_wa_q == d_ra1);
        rt_e = d_valid & d_re2 & (d_ra2 != '0) & e_we_q & (e_wa_q == d_ra2);
        rt_m = d_valid & d_re2 & (d_ra2 != '0) & m_we_q & (m_wa_q == d_ra2);
        rt_w = d_valid & d_re2 & (d_ra2 != '0) & w_we_q & (w_wa_q == d_ra2);

        stall_rs = (rs_e & (e_tnew_q > d_tuse_rs)) |
                   (rs_m & (m_tnew_q > d_tuse_rs)) |
                   (rs_w & (w_tnew_q > d_tuse_rs));
        stall_rt = (rt_e & (e_tnew_q > d_tuse_rt)) |
                   (rt_m & (m_tnew_q > d_tuse_rt)) |
                   (rt_w & (w_tnew_q > d_tuse_rt));
        stall    = stall_rs | stall_rt;
        bubble   = stall | flush;

        fwd_rs_sel = pick_sel(rs_e, rs_m, rs_w, e_tnew_q, m_tnew_q, w_tnew_q);
        fwd_rt_sel = pick_sel(rt_e, rt_m, rt_w, e_tnew_q, m_tnew_q, w_tnew_q);
        e_tnew     = e_tnew_q;
        m_tnew     = m_tnew_q;
    end

    always_comb begin
        w_we_d   = m_we_q;
        w_wa_d   = m_wa_q;
        w_tnew_d = sat_dec(m_tnew_q);
        m_we_d   = e_we_q;
        m_wa_d   = e_wa_q;
        m_tnew_d = sat_dec(e_tnew_q);
        e_we_d   = 1'b0;
        e_wa_d   = '0;
        e_tnew_d = '0;
        if (!bubble) begin
            e_we_d   = d_we & d_valid;
            e_wa_d   = d_wa;
            e_tnew_d = d_tnew;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_we_q   <= 1'b0;
            e_wa_q   <= '0;
            e_tnew_q <= '0;
            m_we_q   <= 1'b0;
            m_wa_q   <= '0;
            m_tnew_q <= '0;
            w_we_q   <= 1'b0;
            w_wa_q   <= '0;
            w_tnew_q <= '0;
        end else begin
            e_we_q   <= e_we_d;
            e_wa_q   <= e_wa_d;
            e_tnew_q <= e_tnew_d;
            m_we_q   <= m_we_d;
            m_wa_q   <= m_wa_d;
            m_tnew_q <= m_tnew_d;
            w_we_q   <= w_we_d;
            w_wa_q   <= w_wa_d;
            w_tnew_q <= w_tnew_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall  ? stall_cnt_q + 32'd1  : stall_cnt_q;
        bubble_cnt_d = bubble ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Inputs change 1 ns after a rising
// edge, and the outputs are checked 1 ns after that, well away from any edge.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d_valid, d_re1, d_re2, d_we, flush;
    logic [4:0] d_ra1, d_ra2, d_wa, d_tuse_rs, d_tuse_rt, d_tnew;
    logic       stall;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic [4:0] e_tnew, m_tnew;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.AW(5), .TW(5)) dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
        .d_re1(d_re1), .d_re2(d_re2), .d_ra1(d_ra1), .d_ra2(d_ra2),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_we(d_we), .d_wa(d_wa), .d_tnew(d_tnew), .flush(flush),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .e_tnew(e_tnew), .m_tnew(m_tnew)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic r1, input logic [4:0] a1,
                         input logic [4:0] u1, input logic r2, input logic [4:0] a2,
                         input logic [4:0] u2, input logic we, input logic [4:0] wa,
                         input logic [4:0] tn);
        d_valid = v;  d_re1 = r1; d_ra1 = a1; d_tuse_rs = u1;
        d_re2 = r2;   d_ra2 = a2; d_tuse_rt = u2;
        d_we = we;    d_wa = wa;  d_tnew = tn;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #11;
        chk("rst_stall", stall, 0);
        chk("rst_fwd_rs", fwd_rs_sel, 0);
        chk("rst_fwd_rt", fwd_rt_sel, 0);
        chk("rst_e_tnew", e_tnew, 0);
        chk("rst_m_tnew", m_tnew, 0);
`ifdef HAZARD_STATS_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        reset_n = 1'b1;
        tick();

        // addu $3 (tnew=1), then a reader of $3 with tuse=1, then one with tuse=0
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 3, 1);
        chk("addu_nostall", stall, 0);
        tick();
        set_d(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("addu_e_tnew", e_tnew, 1);
        chk("addu_rd_stall", stall, 0);
        chk("addu_rd_fwd", fwd_rs_sel, 0);
        tick();
        set_d(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        chk("addu_m_tnew", m_tnew, 0);
        chk("addu_m_fwd", fwd_rs_sel, 2);
        chk("addu_m_stall", stall, 0);
        chk("addu_e_bub", e_tnew, 0);
        idle(3);

        // lw $5 (tnew=2), then beq $5,$6: two stall cycles, then W forwards
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 5, 2);
        tick();
        set_d(1, 1, 5, 0, 1, 6, 0, 0, 0, 0);
        chk("lw_beq_stall1", stall, 1);
        chk("lw_beq_fwd1", fwd_rs_sel, 0);
        tick();
        chk("lw_beq_stall2", stall, 1);
        chk("lw_beq_m_tnew", m_tnew, 1);
        chk("lw_beq_e_bub", e_tnew, 0);
        tick();
        chk("lw_beq_stall3", stall, 0);
        chk("lw_beq_fwd3", fwd_rs_sel, 3);
        chk("lw_beq_rt", fwd_rt_sel, 0);
`ifdef HAZARD_STATS_EN
        chk("lw_beq_stall_cnt", stall_cnt, 2);
        chk("lw_beq_bubble_cnt", bubble_cnt, 2);
`endif
        idle(3);

        // lw $5, then sw with rt=$5 (tuse_rt=2): no stall
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 5, 2);
        tick();
        set_d(1, 1, 2, 1, 1, 5, 2, 0, 0, 0);
        chk("lw_sw_stall", stall, 0);
        chk("lw_sw_fwd_rt", fwd_rt_sel, 0);
        chk("lw_sw_fwd_rs", fwd_rs_sel, 0);
        idle(3);

        // writer to $0, then reader of $0
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 0, 2);
        tick();
        set_d(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("r0_stall", stall, 0);
        chk("r0_fwd_rs", fwd_rs_sel, 0);
        chk("r0_fwd_rt", fwd_rt_sel, 0);
        idle(3);

        // jal in E, jr $31 in D; then a younger ori $31 beats the ready jal in M
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 31, 0);
        tick();
        set_d(1, 1, 31, 0, 0, 0, 0, 0, 0, 0);
        chk("jr_fwd_e", fwd_rs_sel, 1);
        chk("jr_stall_e", stall, 0);
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 31, 1);
        tick();
        set_d(1, 1, 31, 0, 0, 0, 0, 0, 0, 0);
        chk("ori_young_stall", stall, 1);
        chk("ori_young_fwd", fwd_rs_sel, 0);
        tick();
        chk("ori_m_fwd", fwd_rs_sel, 2);
        chk("ori_m_stall", stall, 0);
        idle(3);

        // flush kills the writer entering E
        flush = 1'b1;
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 7, 1);
        tick();
        flush = 1'b0;
        set_d(1, 1, 7, 0, 1, 7, 0, 0, 0, 0);
        chk("flush_stall", stall, 0);
        chk("flush_fwd", fwd_rs_sel, 0);
        chk("flush_e_tnew", e_tnew, 0);
        idle(3);

        // stalled lw hazard, then reset in the middle of the stall
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 5, 2);
        tick();
        set_d(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_pre_stall", stall, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_e_tnew", e_tnew, 0);
`ifdef HAZARD_STATS_EN
        chk("mid_rst_stall_cnt", stall_cnt, 0);
`endif
        #1 reset_n = 1'b1;
        tick();
        chk("post_rst_stall", stall, 0);
        chk("post_rst_fwd", fwd_rs_sel, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

endmodule
